pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/ras_stack.sv | 46 ++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared branch-decode constants and the condition-code evaluator
// used by the PC sequencer.
package cpu_pkg;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_BCOND = 8'h54;
    localparam logic [6:0]  OP_CBZ   = 7'b0110100;
    localparam logic [6:0]  OP_CBNZ  = 7'b0110101;
    localparam logic [21:0] OP_BR    = 22'h3587C0;
    localparam logic [21:0] OP_RET   = 22'h3597C0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    // Even codes give the base test; odd codes invert it, except 1111 which is always.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        {n, z, c, v} = nzcv;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond[0] && cond != COND_NV)
            return ~base;
        return base;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push to a full stack overwrites the
// oldest entry while the occupancy count saturates.
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    assign ptr_inc = ptr_q + PTR_W'(1);
    assign ptr_dec = ptr_q - PTR_W'(1);
    assign top     = mem_q[ptr_q];
    assign empty   = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            mem_q[ptr_inc] <= push_data;
            ptr_q          <= ptr_inc;
            if (cnt_q != CNT_W'(RAS_DEPTH))
                cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && cnt_q != '0) begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: decodes branches, computes the next pc,
// tracks BL/RET through a return-address stack and flags RAS mispredicts.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    input  logic            stall,
    input  logic [3:0]      flags,
    input  logic [PC_W-1:0] rt_val,
    output logic [PC_W-1:0] pc,
    output logic            redirect,
    output logic            link_valid,
    output logic [PC_W-1:0] link_addr,
    output logic            ras_mispredict
);
    logic [PC_W-1:0] pc_q, link_addr_q;
    logic            redirect_q, link_valid_q, mispredict_q;

    logic            accept;
    logic            is_b, is_bl, is_bcond, is_cbz, is_cbnz, is_br, is_ret;
    logic [PC_W-1:0] pc_plus4, off26, off19, rt_tgt, pc_d;
    logic            taken_d, mispredict_d;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty, ras_push, ras_pop;

    always_comb begin
        accept   = inst_valid & ~stall;
        is_b     = (inst[31:26] == OP_B);
        is_bl    = (inst[31:26] == OP_BL);
        is_bcond = (inst[31:24] == OP_BCOND) & ~inst[4];
        is_cbz   = (inst[30:24] == OP_CBZ);
        is_cbnz  = (inst[30:24] == OP_CBNZ);
        is_br    = (inst[31:10] == OP_BR)  & (inst[4:0] == 5'd0);
        is_ret   = (inst[31:10] == OP_RET) & (inst[4:0] == 5'd0);

        pc_plus4 = pc_q + PC_W'(4);
        off26    = {{(PC_W-28){inst[25]}}, inst[25:0], 2'b00};
        off19    = {{(PC_W-21){inst[23]}}, inst[23:5], 2'b00};
        rt_tgt   = {rt_val[PC_W-1:2], 2'b00};

        taken_d = 1'b0;
        pc_d    = pc_plus4;
        if (is_b || is_bl) begin
            taken_d = 1'b1;
            pc_d    = pc_q + off26;
        end else if (is_br || is_ret) begin
            taken_d = 1'b1;
            pc_d    = rt_tgt;
        end else if ((is_bcond && cond_pass(inst[3:0], flags)) ||
                     (is_cbz  && rt_val == '0) ||
                     (is_cbnz && rt_val != '0)) begin
            taken_d = 1'b1;
            pc_d    = pc_q + off19;
        end

        ras_push     = accept & is_bl;
        ras_pop      = accept & is_ret & ~ras_empty;
        mispredict_d = is_ret & (ras_empty | (ras_top != rt_tgt));
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // link_addr keeps its last value between BLs; only link_valid qualifies it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_VECTOR;
            redirect_q   <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            mispredict_q <= 1'b0;
        end else if (accept) begin
            pc_q         <= pc_d;
            redirect_q   <= taken_d;
            link_valid_q <= is_bl;
            mispredict_q <= mispredict_d;
            if (is_bl)
                link_addr_q <= pc_plus4;
        end else begin
            redirect_q   <= 1'b0;
            link_valid_q <= 1'b0;
            mispredict_q <= 1'b0;
        end
    end

    assign pc             = pc_q;
    assign redirect       = redirect_q;
    assign link_valid     = link_valid_q;
    assign link_addr      = link_addr_q;
    assign ras_mispredict = mispredict_q;

endmodule
